mem_ctrl: RTL and testbench

Byte-serial memory controller between the pipeline and the 8-bit synchronous unified RAM. It serves two requesters: the instruction-fetch port (32-bit reads only) and the data port (load/store of 1, 2 or 4 bytes). It assembles and disassembles little-endian words one byte per cycle and arbitrates with data-port priority. Its instruction port drives the `ram_busy` / `ram_read` / `ram_ready` handshake of the IF stage.

---
 rtl/mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial controller between the pipeline (fetch + load/store ports) and an
// 8-bit synchronous RAM; words are assembled/split little-endian, one byte per cycle.
module mem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_busy,
    output logic        inst_ready,
    output logic [31:0] inst_data,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_len,
    input  logic [31:0] data_wdata,
    output logic        data_busy,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_next;
    logic        port_data, port_data_d;
    logic [31:0] addr, addr_d, wdata, wdata_d, word, word_d;
    logic [2:0]  n, n_d, cnt, cnt_d;
    logic        busy, busy_d, inst_ready_d, data_ready_d, ram_wr_d;
    logic [31:0] inst_data_d, data_rdata_d, ram_a_d;
    logic [7:0]  ram_dout_d;
    logic [2:0]  len_n;
    logic [1:0]  cap_idx;
    logic        accept, last;

    assign len_n   = (data_len == 2'b00) ? 3'd1 : (data_len == 2'b01) ? 3'd2 : 3'd4;
    assign accept  = data_write | data_read | inst_read;
    // cnt equals the number of edges since acceptance; the final edge enters DONE
    assign last    = (cnt == n + 3'd1);
    assign cap_idx = 2'(cnt - 3'd2);

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        logic [31:0] sh;
        sh = w >> {i, 3'b000};
        return sh[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_write)     state_next = WRITE;
                else if (data_read) state_next = READ;
                else if (inst_read) state_next = READ;
            end
            READ, WRITE: if (last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        port_data_d  = port_data;
        addr_d       = addr;
        wdata_d      = wdata;
        word_d       = word;
        n_d          = n;
        cnt_d        = cnt;
        ram_a_d      = ram_a;
        ram_dout_d   = ram_dout;
        ram_wr_d     = 1'b0;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_data_d  = inst_data;
        data_rdata_d = data_rdata;
        busy_d       = (state_next != IDLE);
        case (state)
            IDLE: if (accept) begin
                port_data_d = data_write | data_read;
                addr_d      = (data_write | data_read) ? data_addr : inst_addr;
                n_d         = (data_write | data_read) ? len_n : 3'd4;
                wdata_d     = data_wdata;
                word_d      = 32'd0;
                cnt_d       = 3'd1;
                ram_a_d     = addr_d;
                if (data_write) begin
                    ram_dout_d = data_wdata[7:0];
                    ram_wr_d   = 1'b1;
                end
            end
            READ: begin
                cnt_d = cnt + 3'd1;
                if (cnt < n) ram_a_d = addr + {29'd0, cnt};
                // RAM answers one edge after it samples the address, so byte j lands at edge j+2
                if (cnt >= 3'd2) begin
                    case (cap_idx)
                        2'd0: word_d[7:0]   = ram_din;
                        2'd1: word_d[15:8]  = ram_din;
                        2'd2: word_d[23:16] = ram_din;
                        default: word_d[31:24] = ram_din;
                    endcase
                end
                if (last) begin
                    if (port_data) begin
                        data_rdata_d = word_d;
                        data_ready_d = 1'b1;
                    end else begin
                        inst_data_d  = word_d;
                        inst_ready_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt + 3'd1;
                if (cnt < n) begin
                    ram_a_d    = addr + {29'd0, cnt};
                    ram_dout_d = byte_of(wdata, cnt[1:0]);
                    ram_wr_d   = 1'b1;
                end
                if (last) begin
                    if (port_data) data_ready_d = 1'b1;
                    else           inst_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_data  <= 1'b0;
            addr       <= 32'd0;
            wdata      <= 32'd0;
            word       <= 32'd0;
            n          <= 3'd0;
            cnt        <= 3'd0;
            busy       <= 1'b0;
            ram_a      <= 32'd0;
            ram_dout   <= 8'd0;
            ram_wr     <= 1'b0;
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            inst_data  <= 32'd0;
            data_rdata <= 32'd0;
        end else begin
            port_data  <= port_data_d;
            addr       <= addr_d;
            wdata      <= wdata_d;
            word       <= word_d;
            n          <= n_d;
            cnt        <= cnt_d;
            busy       <= busy_d;
            ram_a      <= ram_a_d;
            ram_dout   <= ram_dout_d;
            ram_wr     <= ram_wr_d;
            inst_ready <= inst_ready_d;
            data_ready <= data_ready_d;
            inst_data  <= inst_data_d;
            data_rdata <= data_rdata_d;
        end
    end

    assign inst_busy = busy;
    assign data_busy = busy;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM, transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_read = 1'b0, data_read = 1'b0, data_write = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
    logic [1:0]  data_len = '0;
    logic        inst_busy, inst_ready, data_busy, data_ready, ram_wr;
    logic [31:0] inst_data, data_rdata, ram_a;
    logic [7:0]  ram_din = '0, ram_dout;

    int checks = 0, failures = 0;
    int wr_cnt = 0, dr_cnt = 0;
    logic [31:0] a_seq [4];

    mem_ctrl dut (
        .clk(clk), .reset(reset),
        .inst_read(inst_read), .inst_addr(inst_addr), .inst_busy(inst_busy),
        .inst_ready(inst_ready), .inst_data(inst_data),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
        .data_len(data_len), .data_wdata(data_wdata), .data_busy(data_busy),
        .data_ready(data_ready), .data_rdata(data_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    // RAM seen by the DUT and an independent reference image kept by the model
    logic [7:0] mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction
    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        mem[a] = b;
        ref_mem[a] = b;
    endtask

    always @(posedge clk) begin
        if (ram_wr) mem[ram_a] = ram_dout;
        ram_din <= rd_mem(ram_a);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: busy for n+2 cycles, ready in the last, bytes on cycles 1..n
    logic        m_act = 0, m_wr = 0, m_data = 0, m_clean = 1;
    int          m_cyc = 0, m_n = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, e_inst = 0, e_data = 0;

    always @(posedge clk) begin
        logic [31:0] w;
        if (m_act && m_wr && m_cyc <= m_n)
            ref_mem[m_addr + 32'(m_cyc - 1)] = m_wdata[8*(m_cyc-1) +: 8];
        if (reset) begin
            m_act = 0; m_clean = 1; e_inst = 0; e_data = 0;
        end else if (m_act) begin
            if (m_cyc == m_n + 2) m_act = 0;
            else begin
                m_cyc++;
                if (m_cyc == m_n + 2 && !m_wr) begin
                    w = 0;
                    for (int j = 0; j < m_n; j++) w[8*j +: 8] = rd_ref(m_addr + 32'(j));
                    if (m_data) e_data = w; else e_inst = w;
                end
            end
        end else if (data_write || data_read || inst_read) begin
            m_act = 1; m_cyc = 1; m_clean = 0;
            m_wr = data_write;
            m_data = data_write || data_read;
            m_addr = m_data ? data_addr : inst_addr;
            m_n = !m_data ? 4 : (data_len == 2'b00) ? 1 : (data_len == 2'b01) ? 2 : 4;
            m_wdata = data_wdata;
        end
    end

    always @(negedge clk) begin
        logic exp_wr;
        exp_wr = m_act && m_wr && m_cyc <= m_n;
        chk("inst_busy", inst_busy, m_act);
        chk("data_busy", data_busy, m_act);
        chk("inst_ready", inst_ready, m_act && m_cyc == m_n + 2 && !m_data);
        chk("data_ready", data_ready, m_act && m_cyc == m_n + 2 && m_data);
        chk("inst_data", inst_data, e_inst);
        chk("data_rdata", data_rdata, e_data);
        chk("ram_wr", ram_wr, exp_wr);
        if (m_act && m_cyc <= m_n) chk("ram_a", ram_a, m_addr + 32'(m_cyc - 1));
        if (exp_wr) chk("ram_dout", ram_dout, m_wdata[8*(m_cyc-1) +: 8]);
        if (m_clean) begin
            chk("ram_a_rst", ram_a, 32'd0);
            chk("ram_dout_rst", ram_dout, 32'd0);
        end
        if (ram_wr) wr_cnt++;
        if (data_ready) dr_cnt++;
    end

    // Waits for the chosen ready; lat counts busy cycles, a_seq records the first ram_a values
    task automatic wait_ready(input logic is_data, input string name, output int lat);
        int t;
        lat = 0;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (inst_busy) begin
                lat++;
                if (lat <= 4) a_seq[lat-1] = ram_a;
            end
            if (is_data ? data_ready : inst_ready) break;
        end
        if (t == 20) begin
            checks++; failures++;
            $display("FAIL %s: no ready within 20 cycles", name);
        end
    endtask

    initial begin
        int lat;
        int d0;
        poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'hA0); poke(32'h1003, 8'h00);
        poke(32'h0000, 8'h44); poke(32'h0001, 8'h33); poke(32'h0002, 8'h22); poke(32'h0003, 8'h11);
        poke(32'h0010, 8'h5A);
        poke(32'hFFFFFFFE, 8'hAA); poke(32'hFFFFFFFF, 8'hBB);
        poke(32'h3000, 8'h0D); poke(32'h3001, 8'hF0); poke(32'h3002, 8'hFE); poke(32'h3003, 8'hCA);

        repeat (3) @(negedge clk);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_busy", {31'd0, inst_busy | data_busy | inst_ready | data_ready | ram_wr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // word fetch
        inst_read = 1'b1; inst_addr = 32'h1000;
        wait_ready(1'b0, "fetch", lat);
        inst_read = 1'b0;
        chk("fetch_word", inst_data, 32'h00A00513);
        chk("fetch_latency", lat, 6);
        @(negedge clk);

        // word store then half load
        wr_cnt = 0;
        data_write = 1'b1; data_addr = 32'h2000; data_len = 2'b10; data_wdata = 32'hDEADBEEF;
        wait_ready(1'b1, "store", lat);
        data_write = 1'b0;
        chk("store_wr_cycles", wr_cnt, 4);
        chk("store_bytes", {rd_mem(32'h2003), rd_mem(32'h2002), rd_mem(32'h2001), rd_mem(32'h2000)}, 32'hDEADBEEF);
        @(negedge clk);
        data_read = 1'b1; data_addr = 32'h2002; data_len = 2'b01;
        wait_ready(1'b1, "half_load", lat);
        data_read = 1'b0;
        chk("half_load", data_rdata, 32'h0000DEAD);
        chk("half_latency", lat, 4);
        @(negedge clk);

        // byte load: zero extension and 3-cycle busy
        data_read = 1'b1; data_addr = 32'h2003; data_len = 2'b00;
        wait_ready(1'b1, "byte_load", lat);
        data_read = 1'b0;
        chk("byte_load", data_rdata, 32'h000000DE);
        chk("byte_latency", lat, 3);
        @(negedge clk);

        // half store, then word load of the same spot
        data_write = 1'b1; data_addr = 32'h4000; data_len = 2'b01; data_wdata = 32'h99991234;
        wait_ready(1'b1, "half_store", lat);
        data_write = 1'b0;
        @(negedge clk);
        data_read = 1'b1; data_addr = 32'h4000; data_len = 2'b11;
        wait_ready(1'b1, "word_load", lat);
        data_read = 1'b0;
        chk("half_store_readback", data_rdata, 32'h00001234);
        @(negedge clk);

        // arbitration: data first, fetch after the DONE cycle
        inst_read = 1'b1; inst_addr = 32'h0;
        data_read = 1'b1; data_addr = 32'h10; data_len = 2'b00;
        wait_ready(1'b1, "arb_data", lat);
        data_read = 1'b0;
        chk("arb_data_val", data_rdata, 32'h0000005A);
        wait_ready(1'b0, "arb_inst", lat);
        inst_read = 1'b0;
        chk("arb_inst_val", inst_data, 32'h11223344);
        chk("arb_inst_latency", lat, 6);
        @(negedge clk);

        // address wrap
        inst_read = 1'b1; inst_addr = 32'hFFFFFFFE;
        wait_ready(1'b0, "wrap", lat);
        inst_read = 1'b0;
        chk("wrap_a0", a_seq[0], 32'hFFFFFFFE);
        chk("wrap_a1", a_seq[1], 32'hFFFFFFFF);
        chk("wrap_a2", a_seq[2], 32'h00000000);
        chk("wrap_a3", a_seq[3], 32'h00000001);
        chk("wrap_word", inst_data, 32'h3344BBAA);
        @(negedge clk);

        // fetch dropped and redirected mid-flight
        inst_read = 1'b1; inst_addr = 32'h1000;
        repeat (2) @(negedge clk);
        inst_read = 1'b0;
        @(negedge clk);
        inst_read = 1'b1; inst_addr = 32'h3000;
        wait_ready(1'b0, "drop_old", lat);
        chk("drop_old_word", inst_data, 32'h00A00513);
        wait_ready(1'b0, "drop_new", lat);
        inst_read = 1'b0;
        chk("drop_new_word", inst_data, 32'hCAFEF00D);
        @(negedge clk);

        // reset in the middle of a word store
        poke(32'h5000, 8'h00); poke(32'h5001, 8'h00); poke(32'h5002, 8'h00); poke(32'h5003, 8'h00);
        wr_cnt = 0; d0 = dr_cnt;
        data_write = 1'b1; data_addr = 32'h5000; data_len = 2'b10; data_wdata = 32'h11223344;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ram_wr", ram_wr, 1'b0);
        chk("rst_mid_outs", {ram_a | data_rdata | inst_data | {24'd0, ram_dout}}, 32'd0);
        data_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_mid_wr_cycles", wr_cnt, 2);
        chk("rst_mid_bytes", {rd_mem(32'h5003), rd_mem(32'h5002), rd_mem(32'h5001), rd_mem(32'h5000)}, 32'h00003344);
        chk("rst_mid_no_ready", dr_cnt - d0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
